// File: rtl/serial_min_pkg.sv
// Shared types and sizing helpers for the bit-serial minimum selector.
// Contents: state_t FSM encoding (IDLE, CMP, DONE) and the cnt_width() helper.
package serial_min_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step-counter width for n steps; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_min_slice.sv
// One DIGIT-wide compare slice of the sticky greater/less flag chain.
// Ports: i_a/i_b digits, i_gt/i_lt flags in; o_gt/o_lt updated flags out.
module serial_min_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_gt,
    input  logic             i_lt,
    output logic             o_gt,
    output logic             o_lt
);

    // A decided flag blocks the other; both stay set once raised.
    assign o_gt = i_gt | (~i_lt & (i_a > i_b));
    assign o_lt = i_lt | (~i_gt & (i_a < i_b));

endmodule

// File: rtl/serial_min_unit.sv
// Bit-serial MSB-first min(A,B): DIGIT bits resolved per cycle via one slice.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b in handshake,
//        out_valid/out_ready/out_min/out_sel/out_eq result handshake.
// Option: SERIAL_MIN_MAXOUT_EN adds out_max = max(A,B).
module serial_min_unit
    import serial_min_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic             out_sel,
    output logic             out_eq
`ifdef SERIAL_MIN_MAXOUT_EN
    ,
    output logic [WIDTH-1:0] out_max
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic            r_gt;
    logic            r_lt;
    logic [CW-1:0]   r_cnt;

    logic [WIDTH-1:0] w_a_rot;
    logic [WIDTH-1:0] w_b_rot;
    logic            w_gt;
    logic            w_lt;
    logic            w_done;

    serial_min_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .i_a (r_a[WIDTH-1 -: DIGIT]),
        .i_b (r_b[WIDTH-1 -: DIGIT]),
        .i_gt(r_gt),
        .i_lt(r_lt),
        .o_gt(w_gt),
        .o_lt(w_lt)
    );

    // After N rotations the registers hold the original operands again.
    generate
        if (DIGIT == WIDTH) begin : g_norot
            assign w_a_rot = r_a;
            assign w_b_rot = r_b;
        end else begin : g_rot
            assign w_a_rot = {r_a[WIDTH-DIGIT-1:0], r_a[WIDTH-1 -: DIGIT]};
            assign w_b_rot = {r_b[WIDTH-DIGIT-1:0], r_b[WIDTH-1 -: DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    r_a   <= w_a_rot;
                    r_b   <= w_b_rot;
                    r_gt  <= w_gt;
                    r_lt  <= w_lt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result muxes are gated so every output reads 0 outside DONE.
    assign w_done    = (r_state == DONE);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = w_done;
    assign out_min   = w_done ? (r_gt ? r_b : r_a) : '0;
    assign out_sel   = w_done & r_gt;
    assign out_eq    = w_done & ~r_gt & ~r_lt;

`ifdef SERIAL_MIN_MAXOUT_EN
    assign out_max   = w_done ? (r_gt ? r_a : r_b) : '0;
`endif

endmodule
